// File: rtl/perceptron_trainer.sv
// Perceptron training stage: queues resolved-branch updates, filters those needing training,
// and performs a read-modify-write of the weight vector through a shared read port.
module perceptron_trainer #(
  parameter int unsigned NUM_PERCEPTRONS = 128,
  parameter int unsigned HISTORY_LENGTH  = 32,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH      = $clog2(NUM_PERCEPTRONS),
  parameter int unsigned SUM_WIDTH       = WEIGHT_WIDTH + $clog2(HISTORY_LENGTH + 2),
  parameter int unsigned THETA           = 75,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         upd_valid,
  output logic                                         upd_ready,
  input  logic [ADDR_WIDTH-1:0]                        upd_addr,
  input  logic [HISTORY_LENGTH-1:0]                    upd_history,
  input  logic                                         upd_taken,
  input  logic signed [SUM_WIDTH-1:0]                  upd_sum,
  output logic                                         rd_req,
  input  logic                                         rd_gnt,
  output logic [ADDR_WIDTH-1:0]                        rd_addr,
  input  logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0]    rd_weights,
  output logic                                         wr_en,
  output logic [ADDR_WIDTH-1:0]                        wr_addr,
  output logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0]    wr_weights,
  output logic                                         busy,
  output logic [31:0]                                  train_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned MAG_W = SUM_WIDTH + 1;
  localparam int unsigned NW    = HISTORY_LENGTH + 1;
  localparam logic [WEIGHT_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam logic [WEIGHT_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     addr;
    logic [HISTORY_LENGTH-1:0] history;
    logic                      taken;
    logic [SUM_WIDTH-1:0]      sum;
  } upd_t;

  typedef enum logic [1:0] {IDLE, READ, COMPUTE, WRITE} state_t;

  upd_t                                     fifo_mem [FIFO_DEPTH];
  upd_t                                     upd_in;
  upd_t                                     head;
  logic [PTR_W-1:0]                         wr_ptr_q;
  logic [PTR_W-1:0]                         rd_ptr_q;
  logic [CNT_W-1:0]                         count_q;
  logic [CNT_W-1:0]                         count_d;
  logic                                     push;
  logic                                     pop;
  logic                                     latch;
  logic                                     head_train;
  logic                                     head_pred;
  logic [MAG_W-1:0]                         sum_ext;
  logic [MAG_W-1:0]                         sum_mag;
  state_t                                   state_q;
  state_t                                   state_d;
  logic [HISTORY_LENGTH-1:0]                hist_q;
  logic                                     taken_q;
  logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] w_q;
  logic [HISTORY_LENGTH:0][WEIGHT_WIDTH-1:0] new_w;

  // One saturating step of +1 (up) or -1 on a two's-complement weight.
  function automatic logic [WEIGHT_WIDTH-1:0] sat_step(input logic [WEIGHT_WIDTH-1:0] w,
                                                       input logic                    up);
    if (up) return (w == W_MAX) ? w : w + WEIGHT_WIDTH'(1);
    return (w == W_MIN) ? w : w - WEIGHT_WIDTH'(1);
  endfunction

  always_comb begin
    upd_in         = '0;
    upd_in.addr    = upd_addr;
    upd_in.history = upd_history;
    upd_in.taken   = upd_taken;
    upd_in.sum     = upd_sum;
  end

  assign push    = upd_valid && upd_ready;
  assign head    = fifo_mem[rd_ptr_q];
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Magnitude taken one bit wider so the most-negative sum stays representable.
  always_comb begin
    sum_ext    = {head.sum[SUM_WIDTH-1], head.sum};
    head_pred  = !head.sum[SUM_WIDTH-1];
    sum_mag    = head_pred ? sum_ext : (~sum_ext + MAG_W'(1));
    head_train = (head_pred != head.taken) || (sum_mag <= MAG_W'(THETA));
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
          if (head_train) state_d = READ;
        end
      end
      READ: begin
        if (rd_gnt) begin
          latch   = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // x_0 is the bias input (+1); t*x_i is +1 exactly when the outcome matches the history bit.
  assign new_w[0] = sat_step(w_q[0], taken_q);
  for (genvar i = 1; i < NW; i++) begin : g_upd
    assign new_w[i] = sat_step(w_q[i], taken_q == hist_q[i-1]);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= upd_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      upd_ready <= 1'b0;
      rd_req    <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q   <= count_d;
      upd_ready <= (count_d != CNT_W'(FIFO_DEPTH));
      rd_req    <= (state_d == READ);
      wr_en     <= (state_d == WRITE);
      busy      <= (state_d != IDLE) || (count_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      hist_q     <= '0;
      taken_q    <= 1'b0;
      w_q        <= '0;
      wr_addr    <= '0;
      wr_weights <= '0;
      train_cnt  <= '0;
    end else begin
      if (pop) begin
        rd_addr <= head.addr;
        hist_q  <= head.history;
        taken_q <= head.taken;
      end
      if (latch) w_q <= rd_weights;
      if (state_q == COMPUTE) begin
        wr_addr    <= rd_addr;
        wr_weights <= new_w;
        train_cnt  <= train_cnt + 32'd1;
      end
    end
  end

endmodule
